// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared types and constants for the Otter 5-stage pipeline sequencing
// controller: FSM state encoding, EX operand forwarding select codes and the
// shadow records that track the hazard-relevant decode fields of each
// in-flight stage.
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

  // Controller states
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FAULT    = 2'd2
  } ctrl_state_e;

  // EX operand source selects
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // Shadow of the instruction sitting in EX (field order matters: the top
  // builds the ID-side record by concatenation in this order)
  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs1u;
    logic       rs2u;
    logic [4:0] rd;
    logic       rw;
    logic       ld;
    logic       st;
  } stage_shadow_t;

  // Shadow of the instruction sitting in MEM
  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       rw;
    logic       ld;
    logic       st;
  } mem_shadow_t;

  // Shadow of the instruction sitting in WB
  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       rw;
  } wb_shadow_t;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// -----------------------------------------------------------------------------
// fwd_sel
// Forwarding select for one EX operand. A newer producer in MEM beats an
// older one in WB; register x0 is hard-wired zero and never forwards.
// Ports:
//   rs_i, rs_used_i            source index of the EX instruction and whether
//                              it is actually read
//   mem_v_i/mem_rw_i/mem_rd_i  MEM-stage producer
//   wb_v_i/wb_rw_i/wb_rd_i     WB-stage producer
//   sel_o                      FWD_RF / FWD_MEM / FWD_WB
// -----------------------------------------------------------------------------
module fwd_sel
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] rs_i,
  input  logic       rs_used_i,
  input  logic       mem_v_i,
  input  logic       mem_rw_i,
  input  logic [4:0] mem_rd_i,
  input  logic       wb_v_i,
  input  logic       wb_rw_i,
  input  logic [4:0] wb_rd_i,
  output logic [1:0] sel_o
);

  logic mem_hit_s;
  logic wb_hit_s;

  assign mem_hit_s = mem_v_i & mem_rw_i & (mem_rd_i != 5'd0) & (mem_rd_i == rs_i) & rs_used_i;
  assign wb_hit_s  = wb_v_i  & wb_rw_i  & (wb_rd_i  != 5'd0) & (wb_rd_i  == rs_i) & rs_used_i;

  // Priority select: MEM result is the most recent value of the register
  always_comb begin
    sel_o = FWD_RF;
    if (mem_hit_s) begin
      sel_o = FWD_MEM;
    end else if (wb_hit_s) begin
      sel_o = FWD_WB;
    end else begin
      sel_o = FWD_RF;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Sequencing controller for the Otter 5-stage pipeline. Tracks shadow hazard
// fields for EX/MEM/WB and drives stage register enables, bubble flushes and
// EX operand forwarding. Priority: memory stall > taken redirect > load-use.
// A memory access that stays unready for MEM_TIMEOUT wait cycles freezes the
// pipeline in FAULT until reset.
// Ports:
//   CLK, RST                 clock, asynchronous active-high reset
//   ID_*                     decoded fields of the instruction in ID
//   EX_BR_TAKEN              EX instruction redirects the PC
//   MEM_READY                data memory completes the MEM access this cycle
//   PC_WE..MEM_WB_WE         stage register enables
//   IF_ID_FLUSH, ID_EX_FLUSH load a bubble into the stage register
//   FWD_A_SEL, FWD_B_SEL     EX operand source selects
//   FAULT                    memory timeout, pipeline frozen
//   STALL_CNT, FLUSH_CNT     saturating performance counters
// All control outputs are combinational and read as zero while RST is high.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ID_VALID,
  input  logic [4:0]       ID_RS1,
  input  logic [4:0]       ID_RS2,
  input  logic             ID_RS1_USED,
  input  logic             ID_RS2_USED,
  input  logic [4:0]       ID_RD,
  input  logic             ID_REG_WRITE,
  input  logic             ID_MEM_RDEN2,
  input  logic             ID_MEM_WE2,
  input  logic             EX_BR_TAKEN,
  input  logic             MEM_READY,
  output logic             PC_WE,
  output logic             IF_ID_WE,
  output logic             ID_EX_WE,
  output logic             EX_MEM_WE,
  output logic             MEM_WB_WE,
  output logic             IF_ID_FLUSH,
  output logic             ID_EX_FLUSH,
  output logic [1:0]       FWD_A_SEL,
  output logic [1:0]       FWD_B_SEL,
  output logic             FAULT,
  output logic [CNT_W-1:0] STALL_CNT,
  output logic [CNT_W-1:0] FLUSH_CNT
);

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  ctrl_state_e   state_q, state_d;
  logic [7:0]    wait_q, wait_d;
  stage_shadow_t ex_q, id_shadow_d;
  mem_shadow_t   mem_q;
  wb_shadow_t    wb_q;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  logic mem_busy_d, redirect_d, ld_hz_d;
  logic pc_we_d, if_id_we_d, id_ex_we_d, ex_mem_we_d, mem_wb_we_d;
  logic if_id_flush_d, id_ex_flush_d, fault_d;
  logic stall_inc_d, flush_inc_d, shift_d, ex_bubble_d;
  logic [1:0] fwd_a_d, fwd_b_d;

  assign id_shadow_d = {ID_VALID, ID_RS1, ID_RS2, ID_RS1_USED, ID_RS2_USED,
                        ID_RD, ID_REG_WRITE, ID_MEM_RDEN2, ID_MEM_WE2};

  assign mem_busy_d = mem_q.v & (mem_q.ld | mem_q.st) & ~MEM_READY;
  assign redirect_d = ex_q.v & EX_BR_TAKEN;
  assign ld_hz_d    = ID_VALID & ex_q.v & ex_q.ld & ex_q.rw & (ex_q.rd != 5'd0) &
                      (((ex_q.rd == ID_RS1) & ID_RS1_USED) | ((ex_q.rd == ID_RS2) & ID_RS2_USED));

  // Next-state and control decode
  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    pc_we_d       = 1'b0;
    if_id_we_d    = 1'b0;
    id_ex_we_d    = 1'b0;
    ex_mem_we_d   = 1'b0;
    mem_wb_we_d   = 1'b0;
    if_id_flush_d = 1'b0;
    id_ex_flush_d = 1'b0;
    fault_d       = 1'b0;
    stall_inc_d   = 1'b0;
    flush_inc_d   = 1'b0;
    shift_d       = 1'b0;
    ex_bubble_d   = 1'b0;
    case (state_q)
      ST_RUN, ST_MEM_WAIT: begin
        if (mem_busy_d) begin
          // Whole pipeline frozen; redirects wait until memory answers
          stall_inc_d = 1'b1;
          if (state_q == ST_RUN) begin
            state_d = ST_MEM_WAIT;
            wait_d  = 8'd0;
          end else if (wait_q == WAIT_LAST) begin
            state_d = ST_FAULT;
          end else begin
            wait_d = wait_q + 8'd1;
          end
        end else begin
          state_d     = ST_RUN;
          wait_d      = 8'd0;
          shift_d     = 1'b1;
          id_ex_we_d  = 1'b1;
          ex_mem_we_d = 1'b1;
          mem_wb_we_d = 1'b1;
          if (redirect_d) begin
            pc_we_d       = 1'b1;
            if_id_we_d    = 1'b1;
            if_id_flush_d = 1'b1;
            id_ex_flush_d = 1'b1;
            ex_bubble_d   = 1'b1;
            flush_inc_d   = 1'b1;
          end else if (ld_hz_d) begin
            // Hold IF/ID, inject one bubble behind the load
            id_ex_flush_d = 1'b1;
            ex_bubble_d   = 1'b1;
            stall_inc_d   = 1'b1;
          end else begin
            pc_we_d    = 1'b1;
            if_id_we_d = 1'b1;
          end
        end
      end
      ST_FAULT: begin
        fault_d = 1'b1;
      end
      default: begin
        state_d = ST_FAULT;
      end
    endcase
  end

  // FSM state and memory wait counter
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_RUN;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Shadow pipeline: advances with the real stage registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (shift_d) begin
      wb_q  <= '{v: mem_q.v, rd: mem_q.rd, rw: mem_q.rw};
      mem_q <= '{v: ex_q.v, rd: ex_q.rd, rw: ex_q.rw, ld: ex_q.ld, st: ex_q.st};
      ex_q  <= ex_bubble_d ? stage_shadow_t'(0) : id_shadow_d;
    end
  end

  // Saturating performance counters
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_inc_d && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (flush_inc_d && (flush_cnt_q != {CNT_W{1'b1}})) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  fwd_sel u_fwd_a (
    .rs_i     (ex_q.rs1),
    .rs_used_i(ex_q.rs1u),
    .mem_v_i  (mem_q.v),
    .mem_rw_i (mem_q.rw),
    .mem_rd_i (mem_q.rd),
    .wb_v_i   (wb_q.v),
    .wb_rw_i  (wb_q.rw),
    .wb_rd_i  (wb_q.rd),
    .sel_o    (fwd_a_d)
  );

  fwd_sel u_fwd_b (
    .rs_i     (ex_q.rs2),
    .rs_used_i(ex_q.rs2u),
    .mem_v_i  (mem_q.v),
    .mem_rw_i (mem_q.rw),
    .mem_rd_i (mem_q.rd),
    .wb_v_i   (wb_q.v),
    .wb_rw_i  (wb_q.rw),
    .wb_rd_i  (wb_q.rd),
    .sel_o    (fwd_b_d)
  );

  // Everything reads zero while reset is held
  assign PC_WE       = pc_we_d       & ~RST;
  assign IF_ID_WE    = if_id_we_d    & ~RST;
  assign ID_EX_WE    = id_ex_we_d    & ~RST;
  assign EX_MEM_WE   = ex_mem_we_d   & ~RST;
  assign MEM_WB_WE   = mem_wb_we_d   & ~RST;
  assign IF_ID_FLUSH = if_id_flush_d & ~RST;
  assign ID_EX_FLUSH = id_ex_flush_d & ~RST;
  assign FAULT       = fault_d       & ~RST;
  assign FWD_A_SEL   = RST ? FWD_RF : fwd_a_d;
  assign FWD_B_SEL   = RST ? FWD_RF : fwd_b_d;
  assign STALL_CNT   = RST ? {CNT_W{1'b0}} : stall_cnt_q;
  assign FLUSH_CNT   = RST ? {CNT_W{1'b0}} : flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (MEM_TIMEOUT=4, CNT_W=3 so that the
// timeout and counter saturation are reachable in a few cycles).
module tb_pipe_hazard_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       ID_VALID, ID_RS1_USED, ID_RS2_USED;
  logic [4:0] ID_RS1, ID_RS2, ID_RD;
  logic       ID_REG_WRITE, ID_MEM_RDEN2, ID_MEM_WE2;
  logic       EX_BR_TAKEN, MEM_READY;
  logic       PC_WE, IF_ID_WE, ID_EX_WE, EX_MEM_WE, MEM_WB_WE;
  logic       IF_ID_FLUSH, ID_EX_FLUSH, FAULT;
  logic [1:0] FWD_A_SEL, FWD_B_SEL;
  logic [2:0] STALL_CNT, FLUSH_CNT;

  int total = 0;
  int bad   = 0;

  // {PC, IF_ID, ID_EX, EX_MEM, MEM_WB, IF_ID_FLUSH, ID_EX_FLUSH}
  wire [6:0] ctl = {PC_WE, IF_ID_WE, ID_EX_WE, EX_MEM_WE, MEM_WB_WE, IF_ID_FLUSH, ID_EX_FLUSH};
  localparam logic [6:0] C_NORM  = 7'b1111100;
  localparam logic [6:0] C_FROZE = 7'b0000000;
  localparam logic [6:0] C_REDIR = 7'b1111111;
  localparam logic [6:0] C_LDUSE = 7'b0011101;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(3)) dut (
    .CLK(CLK), .RST(RST), .ID_VALID(ID_VALID),
    .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_RS1_USED(ID_RS1_USED), .ID_RS2_USED(ID_RS2_USED),
    .ID_RD(ID_RD), .ID_REG_WRITE(ID_REG_WRITE), .ID_MEM_RDEN2(ID_MEM_RDEN2), .ID_MEM_WE2(ID_MEM_WE2),
    .EX_BR_TAKEN(EX_BR_TAKEN), .MEM_READY(MEM_READY),
    .PC_WE(PC_WE), .IF_ID_WE(IF_ID_WE), .ID_EX_WE(ID_EX_WE), .EX_MEM_WE(EX_MEM_WE), .MEM_WB_WE(MEM_WB_WE),
    .IF_ID_FLUSH(IF_ID_FLUSH), .ID_EX_FLUSH(ID_EX_FLUSH),
    .FWD_A_SEL(FWD_A_SEL), .FWD_B_SEL(FWD_B_SEL), .FAULT(FAULT),
    .STALL_CNT(STALL_CNT), .FLUSH_CNT(FLUSH_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Present an instruction in ID
  task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                        input logic rw, input logic ld, input logic st);
    ID_VALID = v; ID_RS1 = rs1; ID_RS1_USED = u1; ID_RS2 = rs2; ID_RS2_USED = u2;
    ID_RD = rd; ID_REG_WRITE = rw; ID_MEM_RDEN2 = ld; ID_MEM_WE2 = st;
  endtask

  task automatic do_reset;
    RST = 1'b1; EX_BR_TAKEN = 1'b0; MEM_READY = 1'b1;
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick; tick;
    RST = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    // reset-state outputs
    RST = 1'b1; EX_BR_TAKEN = 1'b0; MEM_READY = 1'b1;
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    #2;
    total++; if (ctl !== C_FROZE || FAULT !== 1'b0) begin bad++; $display("FAIL reset_outputs ctl=%b fault=%b exp ctl=0000000 fault=0", ctl, FAULT); end
    total++; if (STALL_CNT !== 3'd0 || FLUSH_CNT !== 3'd0 || FWD_A_SEL !== 2'b00) begin bad++; $display("FAIL reset_cnt stall=%0d flush=%0d fwda=%b exp 0 0 00", STALL_CNT, FLUSH_CNT, FWD_A_SEL); end
    do_reset;
    // SW into MEM, then two unready cycles (second one is in MEM_WAIT)
    set_id(1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1); tick;
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); tick;
    MEM_READY = 1'b0;
    tick; tick;
    #1;
    total++; if (ctl !== C_FROZE || STALL_CNT !== 3'd2) begin bad++; $display("FAIL midrun_wait ctl=%b stall=%0d exp ctl=0000000 stall=2", ctl, STALL_CNT); end
    RST = 1'b1;
    #1;
    total++; if (ctl !== C_FROZE || STALL_CNT !== 3'd0 || FAULT !== 1'b0) begin bad++; $display("FAIL midrun_rst ctl=%b stall=%0d fault=%b exp 0000000 0 0", ctl, STALL_CNT, FAULT); end
    tick;
    RST = 1'b0;
    #1;
    // shadows invalid: memory still unready but no stall
    total++; if (ctl !== C_NORM || STALL_CNT !== 3'd0) begin bad++; $display("FAIL midrun_after ctl=%b stall=%0d exp ctl=1111100 stall=0", ctl, STALL_CNT); end
    MEM_READY = 1'b1;
  endtask

  task automatic test_forward;
    do_reset;
    // ADD x5 ; SUB x6,x5,x3 -> MEM forward on A
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0); tick;
    set_id(1'b1, 5'd5, 1'b1, 5'd3, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0); tick;
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); #1;
    total++; if (FWD_A_SEL !== 2'b01 || FWD_B_SEL !== 2'b00) begin bad++; $display("FAIL fwd_mem a=%b b=%b exp a=01 b=00", FWD_A_SEL, FWD_B_SEL); end
    // ADD x5 ; ADD x9 ; SUB x6,x5,x3 -> WB forward on A
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0); tick;
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0); tick;
    set_id(1'b1, 5'd5, 1'b1, 5'd3, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0); tick;
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); #1;
    total++; if (FWD_A_SEL !== 2'b10 || FWD_B_SEL !== 2'b00) begin bad++; $display("FAIL fwd_wb a=%b b=%b exp a=10 b=00", FWD_A_SEL, FWD_B_SEL); end
    // ADD x5 ; ADD x5 ; SUB x6,x5,x5 -> MEM beats WB on both operands
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0); tick;
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0); tick;
    set_id(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0); tick;
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); #1;
    total++; if (FWD_A_SEL !== 2'b01 || FWD_B_SEL !== 2'b01) begin bad++; $display("FAIL fwd_prio a=%b b=%b exp a=01 b=01", FWD_A_SEL, FWD_B_SEL); end
    // ADD x4 ; ADD x9 ; SUB x6,x1,x4 -> WB forward on B only
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0); tick;
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0); tick;
    set_id(1'b1, 5'd1, 1'b1, 5'd4, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0); tick;
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); #1;
    total++; if (FWD_A_SEL !== 2'b00 || FWD_B_SEL !== 2'b10) begin bad++; $display("FAIL fwd_b_wb a=%b b=%b exp a=00 b=10", FWD_A_SEL, FWD_B_SEL); end
    // ADD x0 ; SUB x6,x0,x0 -> x0 never forwards
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0); tick;
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0); tick;
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); #1;
    total++; if (FWD_A_SEL !== 2'b00 || FWD_B_SEL !== 2'b00) begin bad++; $display("FAIL fwd_x0 a=%b b=%b exp a=00 b=00", FWD_A_SEL, FWD_B_SEL); end
    // ADD x5 ; consumer with rs1=x5 but not used -> no forward
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0); tick;
    set_id(1'b1, 5'd5, 1'b0, 5'd3, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0); tick;
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); #1;
    total++; if (FWD_A_SEL !== 2'b00) begin bad++; $display("FAIL fwd_unused a=%b exp a=00", FWD_A_SEL); end
  endtask

  task automatic test_load_use;
    do_reset;
    // LW x7 ; ADD x8,x7,x1
    set_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0); tick;
    set_id(1'b1, 5'd7, 1'b1, 5'd1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0); #1;
    total++; if (ctl !== C_LDUSE) begin bad++; $display("FAIL lduse_stall ctl=%b exp 0011101", ctl); end
    tick;
    total++; if (ctl !== C_NORM || STALL_CNT !== 3'd1) begin bad++; $display("FAIL lduse_once ctl=%b stall=%0d exp ctl=1111100 stall=1", ctl, STALL_CNT); end
    tick;
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); #1;
    total++; if (FWD_A_SEL !== 2'b10 || FWD_B_SEL !== 2'b00 || STALL_CNT !== 3'd1) begin bad++; $display("FAIL lduse_fwd a=%b b=%b stall=%0d exp a=10 b=00 stall=1", FWD_A_SEL, FWD_B_SEL, STALL_CNT); end
    // LW x0 ; consumer of x0 -> no hazard
    set_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0); tick;
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0); #1;
    total++; if (ctl !== C_NORM) begin bad++; $display("FAIL lduse_x0 ctl=%b exp 1111100", ctl); end
    // LW x7 ; SW using x7 as rs2 -> hazard via B
    set_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0); tick;
    set_id(1'b1, 5'd3, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1); #1;
    total++; if (ctl !== C_LDUSE) begin bad++; $display("FAIL lduse_rs2 ctl=%b exp 0011101", ctl); end
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_branch_vs_loaduse;
    do_reset;
    set_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0); tick;
    set_id(1'b1, 5'd7, 1'b1, 5'd1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    EX_BR_TAKEN = 1'b1; #1;
    total++; if (ctl !== C_REDIR) begin bad++; $display("FAIL br_over_lduse ctl=%b exp 1111111", ctl); end
    tick;
    EX_BR_TAKEN = 1'b0;
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); #1;
    total++; if (FLUSH_CNT !== 3'd1 || STALL_CNT !== 3'd0) begin bad++; $display("FAIL br_counts flush=%0d stall=%0d exp flush=1 stall=0", FLUSH_CNT, STALL_CNT); end
  endtask

  task automatic test_mem_wait;
    do_reset;
    // SW then an independent ADD; SW reaches MEM with ADD in EX
    set_id(1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1); tick;
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0); tick;
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    MEM_READY = 1'b0; EX_BR_TAKEN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (ctl !== C_FROZE) begin bad++; $display("FAIL memwait_frozen cyc=%0d ctl=%b exp 0000000", i, ctl); end
      tick;
    end
    total++; if (STALL_CNT !== 3'd3 || FLUSH_CNT !== 3'd0 || FAULT !== 1'b0) begin bad++; $display("FAIL memwait_cnt stall=%0d flush=%0d fault=%b exp 3 0 0", STALL_CNT, FLUSH_CNT, FAULT); end
    MEM_READY = 1'b1; #1;
    total++; if (ctl !== C_REDIR) begin bad++; $display("FAIL memwait_br_resume ctl=%b exp 1111111", ctl); end
    tick;
    EX_BR_TAKEN = 1'b0; MEM_READY = 1'b0; #1;
    total++; if (ctl !== C_NORM || STALL_CNT !== 3'd3 || FLUSH_CNT !== 3'd1) begin bad++; $display("FAIL memwait_run ctl=%b stall=%0d flush=%0d exp 1111100 3 1", ctl, STALL_CNT, FLUSH_CNT); end
    MEM_READY = 1'b1;
  endtask

  task automatic test_timeout;
    do_reset;
    set_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0); tick;
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); tick;
    MEM_READY = 1'b0;
    // one RUN stall cycle plus four MEM_WAIT cycles
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (FAULT !== 1'b0 || ctl !== C_FROZE) begin bad++; $display("FAIL timeout_pre cyc=%0d fault=%b ctl=%b exp 0 0000000", i, FAULT, ctl); end
      tick;
    end
    total++; if (FAULT !== 1'b1 || ctl !== C_FROZE || STALL_CNT !== 3'd5) begin bad++; $display("FAIL timeout_fault fault=%b ctl=%b stall=%0d exp 1 0000000 5", FAULT, ctl, STALL_CNT); end
    MEM_READY = 1'b1;
    tick; tick;
    total++; if (FAULT !== 1'b1 || ctl !== C_FROZE || STALL_CNT !== 3'd5) begin bad++; $display("FAIL timeout_sticky fault=%b ctl=%b stall=%0d exp 1 0000000 5", FAULT, ctl, STALL_CNT); end
    RST = 1'b1; #1;
    total++; if (FAULT !== 1'b0) begin bad++; $display("FAIL timeout_rst fault=%b exp 0", FAULT); end
    tick;
    RST = 1'b0; #1;
    total++; if (FAULT !== 1'b0 || ctl !== C_NORM) begin bad++; $display("FAIL timeout_clear fault=%b ctl=%b exp 0 1111100", FAULT, ctl); end
  endtask

  task automatic test_back_to_back;
    do_reset;
    // redirect every other cycle: counter must stop at 7
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    EX_BR_TAKEN = 1'b1;
    repeat (6) tick;
    total++; if (FLUSH_CNT !== 3'd3) begin bad++; $display("FAIL b2b_flush_mid flush=%0d exp 3", FLUSH_CNT); end
    repeat (14) tick;
    total++; if (FLUSH_CNT !== 3'd7) begin bad++; $display("FAIL b2b_flush_sat flush=%0d exp 7", FLUSH_CNT); end
    EX_BR_TAKEN = 1'b0;
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset;
    test_forward;
    test_load_use;
    test_branch_vs_loaduse;
    test_mem_wait;
    test_timeout;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage Otter core (IF/ID/EX/MEM/WB).
- Keeps shadow copies of the decoded hazard fields (rd, REG_WRITE, MEM_RDEN2, MEM_WE2, rs1/rs2) for every in-flight stage.
- From these it produces per-stage register write-enables, flushes and EX operand forwarding selects.
- Handles load-use stalls, taken-branch/jump flushes from EX, and data-memory wait, with a timeout fault.

Parameters:
MEM_TIMEOUT, 16, max consecutive MEM_WAIT cycles before FAULT (range 1..255).
CNT_W, 32, width of the saturating stall and flush performance counters.

Ports:
CLK  in  1  system clock, all state on rising edge
RST  in  1  asynchronous, active-high reset
ID_VALID  in  1  ID stage holds a real instruction
ID_RS1, ID_RS2  in  5 each  source register indices in ID
ID_RS1_USED, ID_RS2_USED  in  1 each  source actually read by the instruction
ID_RD  in  5  destination index in ID
ID_REG_WRITE, ID_MEM_RDEN2, ID_MEM_WE2  in  1 each  decoder outputs for the ID instruction
EX_BR_TAKEN  in  1  branch/JAL/JALR in EX redirects the PC
MEM_READY  in  1  data memory completes the access in MEM this cycle
PC_WE, IF_ID_WE, ID_EX_WE, EX_MEM_WE, MEM_WB_WE  out  1 each  stage register enables
IF_ID_FLUSH, ID_EX_FLUSH  out  1 each  load a bubble into the stage register
FWD_A_SEL, FWD_B_SEL  out  2 each  EX operand source: 00 regfile, 01 EX/MEM result, 10 MEM/WB result
FAULT  out  1  memory timeout; pipeline frozen
STALL_CNT, FLUSH_CNT  out  CNT_W each  performance counters

Behaviour:
Shadow state and reset
- Shadow entries: EXs {v, rs1, rs2, rs1u, rs2u, rd, rw, ld, st}, MEMs {v, rd, rw, ld, st}, WBs {v, rd, rw}.
- RST high: all shadow v=0, state=RUN, wait counter=0, both counters=0.
- While RST is high every output is forced to 0.

FSM states: RUN, MEM_WAIT, FAULT.
- RUN -> MEM_WAIT when MEMs.v & (ld|st) & !MEM_READY.
- MEM_WAIT -> RUN when MEM_READY.
- MEM_WAIT -> FAULT when the wait counter reaches MEM_TIMEOUT without MEM_READY.
- FAULT: all enables and flushes 0, FAULT=1. Exit only by RST.

Memory stall (highest priority)
- Condition: MEMs.v & (ld|st) & !MEM_READY, in RUN or MEM_WAIT.
- Every WE=0 and every flush=0; shadows hold.
- EX_BR_TAKEN is ignored during the stall and is re-evaluated once the stall clears.
- STALL_CNT increments.

Taken redirect (else)
- Condition: EXs.v & EX_BR_TAKEN.
- PC_WE=1, IF_ID_FLUSH=1, ID_EX_FLUSH=1, and all other stage WEs=1.
- EXs becomes a bubble (v=0).
- FLUSH_CNT increments by 1 per event.
- Overrides a simultaneous load-use condition.

Load-use (else)
- Condition: ID_VALID & EXs.v & EXs.ld & EXs.rw & EXs.rd!=0, and EXs.rd matches (ID_RS1 & ID_RS1_USED) or (ID_RS2 & ID_RS2_USED).
- PC_WE=0, IF_ID_WE=0, ID_EX_WE=1 with ID_EX_FLUSH=1 (bubble into EX).
- EX_MEM_WE=1, MEM_WB_WE=1.
- Exactly one stall cycle per hazard; STALL_CNT increments.

Normal operation
- All WEs=1, flushes=0.
- Shadows shift: ID->EXs (v=ID_VALID), EXs->MEMs, MEMs->WBs.

Forwarding (combinational from shadows, identical for A/rs1 and B/rs2)
- 01 if MEMs.v & MEMs.rw & MEMs.rd!=0 & MEMs.rd==EXs.rs1 & EXs.rs1u.
- Else 10 on the same match against WBs.
- Else 00.
- The MEM match takes priority. x0 never forwards.

Counters and latency
- Both counters saturate at all-ones and never wrap.
- Control outputs are combinational with zero latency from inputs and shadows.
- The FSM and all shadows update on the clock edge.

Decomposition:
- pipe_ctrl_pkg holds: state enum {RUN, MEM_WAIT, FAULT}; FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10; typedef stage_shadow_t for the shadow struct.
- One sub-module, fwd_sel: the combinational compare for one operand, instantiated for A and for B.

Test Plan:
- Reset mid-run: assert RST during MEM_WAIT -> all outputs 0 immediately, state RUN, counters 0, shadows invalid.
- ADD x5 followed immediately by SUB using x5 -> FWD_A_SEL=01 with the SUB in EX; one more independent instruction later, same operand -> 10; rd=x0 -> 00.
- LW x7 then ADD x8,x7,x1 -> exactly one cycle with PC_WE=0, IF_ID_WE=0, ID_EX_FLUSH=1; ADD then reaches EX with FWD_A_SEL=10; STALL_CNT=1.
- EX_BR_TAKEN=1 in the same cycle as a load-use hazard -> IF_ID_FLUSH=ID_EX_FLUSH=1, PC_WE=1, no stall; FLUSH_CNT=1, STALL_CNT=0.
- SW in MEM with MEM_READY low for 3 cycles -> all WE=0 for 3 cycles, STALL_CNT=3, RUN restored on the 4th cycle.
- MEM_READY held low with MEM_TIMEOUT=4 -> FAULT=1 after 4 wait cycles and stays set with all WE=0 until RST.
